// File: rtl/tdc_pkg.sv
// Shared constants, FSM state type and parameter checks for the TDC edge decoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tdc_pkg;

    localparam int TDC_NUM_TAPS   = 36;
    localparam int TDC_NUM_DECODE = 8;
    localparam int TDC_RUN_LEN    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_ENC  = 2'd2,
        ST_OUT  = 2'd3
    } tdc_state_t;

    // The output width must be able to hold a tap position of NUM_TAPS.
    function automatic bit tdc_width_ok(input int num_taps, input int num_decode);
        return (num_decode < 31) && ((1 << num_decode) > num_taps);
    endfunction

endpackage

// File: rtl/tdc_edge_decoder_if.sv
// Request/result bundle between the sampling stage and the edge decoder.
// Latency: none (wiring only).
// Backpressure: none; go is a one-shot request, busy/overrun report drops.
interface tdc_edge_decoder_if
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS   = TDC_NUM_TAPS,
    parameter int NUM_DECODE = TDC_NUM_DECODE
) ();

    logic                  go;
    logic                  mode_falling;
    logic [NUM_TAPS-1:0]   taps;
    logic                  busy;
    logic                  done;
    logic [NUM_DECODE-1:0] bin;
    logic [NUM_DECODE-1:0] edge_count;
    logic                  no_edge;
    logic                  multi_edge;
    logic                  overrun;

    // Requester side: issues go with the tap snapshot, receives results.
    modport master (
        output go, mode_falling, taps,
        input  busy, done, bin, edge_count, no_edge, multi_edge, overrun
    );

    // Decoder side.
    modport slave (
        input  go, mode_falling, taps,
        output busy, done, bin, edge_count, no_edge, multi_edge, overrun
    );

endinterface

// File: rtl/tdc_edge_match.sv
// Flags every tap index where the selected transition is followed by RUN_LEN confirming taps.
// Latency: combinational.
// Backpressure: none.
module tdc_edge_match #(
    parameter int NUM_TAPS = 36,
    parameter int RUN_LEN  = 4
) (
    input  logic [NUM_TAPS-1:0]         i_taps,
    input  logic                        i_mode_falling,
    output logic [NUM_TAPS-RUN_LEN-1:0] o_match
);

    // Edge tap must differ from the run value; the RUN_LEN taps above it must equal it.
    // Start mode runs on zeros (mode 0), stop mode runs on ones (mode 1).
    always_comb begin
        o_match = '0;
        for (int i = 0; i < NUM_TAPS - RUN_LEN; i++) begin
            o_match[i] = i_taps[i] ^ i_mode_falling;
            for (int k = 1; k <= RUN_LEN; k++) begin
                o_match[i] = o_match[i] & (i_taps[i+k] ~^ i_mode_falling);
            end
        end
    end

endmodule

// File: rtl/tdc_edge_decoder.sv
// Snapshots the delay line on go and reports edge position, candidate count and flags.
// Latency: 4 cycles go->done; one decode per 4 cycles, go on the done cycle is accepted.
// Backpressure: none; go while busy is dropped and reported as overrun with the next done.
module tdc_edge_decoder
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS    = TDC_NUM_TAPS,
    parameter int NUM_DECODE  = TDC_NUM_DECODE,
    parameter int RUN_LEN     = TDC_RUN_LEN,
    parameter bit SELECT_LAST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    tdc_edge_decoder_if.slave    bus
);

    localparam int NUM_MATCH = NUM_TAPS - RUN_LEN;

    if (!tdc_width_ok(NUM_TAPS, NUM_DECODE)) begin : g_bad_width
        $error("NUM_DECODE too narrow for NUM_TAPS");
    end
    if (RUN_LEN < 1 || RUN_LEN > NUM_TAPS - 1) begin : g_bad_run
        $error("RUN_LEN out of range");
    end

    tdc_state_t             r_state;
    tdc_state_t             w_next_state;

    logic                   w_busy;
    logic                   w_capture;
    logic                   w_go_drop;
    logic                   w_load;

    logic [NUM_TAPS-1:0]    r_snap_taps;
    logic                   r_snap_mode;
    logic [NUM_MATCH-1:0]   w_match;
    logic [NUM_MATCH-1:0]   r_match;
    logic [NUM_DECODE-1:0]  w_sel_bin;
    logic [NUM_DECODE-1:0]  w_cnt;
    logic [NUM_DECODE-1:0]  r_sel_bin;
    logic [NUM_DECODE-1:0]  r_cnt;
    logic                   r_ovr;

    logic [NUM_DECODE-1:0]  r_bin;
    logic [NUM_DECODE-1:0]  r_edge_count;
    logic                   r_no_edge;
    logic                   r_multi_edge;
    logic                   r_overrun;
    logic                   r_done;

    tdc_edge_match #(
        .NUM_TAPS (NUM_TAPS),
        .RUN_LEN  (RUN_LEN)
    ) u_match (
        .i_taps         (r_snap_taps),
        .i_mode_falling (r_snap_mode),
        .o_match        (w_match)
    );

    // State register; reset aborts any decode in flight.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next state: fixed walk through the pipeline once a go is accepted.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.go) w_next_state = ST_CAPT;
            ST_CAPT: w_next_state = ST_ENC;
            ST_ENC:  w_next_state = ST_OUT;
            ST_OUT:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: stage enables plus accepted/dropped go qualifiers.
    always_comb begin
        w_busy    = (r_state != ST_IDLE);
        w_capture = (r_state == ST_IDLE) && bus.go;
        w_go_drop = (r_state != ST_IDLE) && bus.go;
        w_load    = (r_state == ST_OUT);
    end

    // Select the lowest or highest match and count all matches.
    always_comb begin
        w_sel_bin = '0;
        w_cnt     = '0;
        for (int i = 0; i < NUM_MATCH; i++) begin
            if (r_match[i]) begin
                if (SELECT_LAST || (w_cnt == '0)) w_sel_bin = NUM_DECODE'(i + 1);
                w_cnt = w_cnt + NUM_DECODE'(1);
            end
        end
    end

    // Pipeline stages, overrun tracking and the held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_taps  <= '0;
            r_snap_mode  <= 1'b0;
            r_match      <= '0;
            r_sel_bin    <= '0;
            r_cnt        <= '0;
            r_ovr        <= 1'b0;
            r_bin        <= '0;
            r_edge_count <= '0;
            r_no_edge    <= 1'b0;
            r_multi_edge <= 1'b0;
            r_overrun    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_capture) begin
                r_snap_taps <= bus.taps;
                r_snap_mode <= bus.mode_falling;
            end
            if (r_state == ST_CAPT) r_match <= w_match;
            if (r_state == ST_ENC) begin
                r_sel_bin <= w_sel_bin;
                r_cnt     <= w_cnt;
            end
            if (w_capture)      r_ovr <= 1'b0;
            else if (w_go_drop) r_ovr <= 1'b1;
            r_done <= w_load;
            if (w_load) begin
                r_bin        <= r_sel_bin;
                r_edge_count <= r_cnt;
                r_no_edge    <= (r_cnt == '0);
                r_multi_edge <= (r_cnt > NUM_DECODE'(1));
                // A go dropped in the OUT cycle itself belongs to this decode.
                r_overrun    <= r_ovr | w_go_drop;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.bin        = r_bin;
    assign bus.edge_count = r_edge_count;
    assign bus.no_edge    = r_no_edge;
    assign bus.multi_edge = r_multi_edge;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_tdc_edge_decoder.sv
// Bench: two decoders (last-edge and first-edge select) driven in parallel,
// checked against a window-scan reference model.
// Directed plan scenarios first, then randomized decodes.
module tb_tdc_edge_decoder;
    import tdc_pkg::*;

    localparam int NT  = 36;
    localparam int ND  = 8;
    localparam int RUN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_bl  = 0;
    int   last_bf  = 0;

    always #5 clk = ~clk;

    tdc_edge_decoder_if #(.NUM_TAPS(NT), .NUM_DECODE(ND)) bus_l ();
    tdc_edge_decoder_if #(.NUM_TAPS(NT), .NUM_DECODE(ND)) bus_f ();

    tdc_edge_decoder #(.NUM_TAPS(NT), .NUM_DECODE(ND), .RUN_LEN(RUN), .SELECT_LAST(1'b1)) u_dut_last (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    tdc_edge_decoder #(.NUM_TAPS(NT), .NUM_DECODE(ND), .RUN_LEN(RUN), .SELECT_LAST(1'b0)) u_dut_first (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit go, input bit m, input logic [NT-1:0] t);
        bus_l.go = go; bus_l.mode_falling = m; bus_l.taps = t;
        bus_f.go = go; bus_f.mode_falling = m; bus_f.taps = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: slide a (RUN+1)-tap window over the line and look for the literal
    // pattern edge,run,run,... where run is 0 for start and 1 for stop.
    task automatic ref_decode(input logic [NT-1:0] t, input bit m,
                              output int bl, output int bf, output int cnt);
        int  hits [$];
        logic [RUN:0] want;
        logic [RUN:0] win;
        want = {(RUN+1){m}};
        want[0] = ~m;
        for (int i = 0; i + RUN <= NT - 1; i++) begin
            for (int k = 0; k <= RUN; k++) win[k] = t[i+k];
            if (win == want) hits.push_back(i + 1);
        end
        cnt = hits.size();
        bl  = (cnt == 0) ? 0 : hits[cnt-1];
        bf  = (cnt == 0) ? 0 : hits[0];
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, ".done"}, bus_l.done, 0);
        check_val({tag, ".busy"}, bus_l.busy, 0);
        check_val({tag, ".bin"},  bus_l.bin, 0);
        check_val({tag, ".cnt"},  bus_l.edge_count, 0);
        check_val({tag, ".noe"},  bus_l.no_edge, 0);
        check_val({tag, ".mul"},  bus_l.multi_edge, 0);
        check_val({tag, ".ovr"},  bus_l.overrun, 0);
        check_val({tag, ".f.done"}, bus_f.done, 0);
        check_val({tag, ".f.bin"},  bus_f.bin, 0);
    endtask

    // Issue go now (cycle 0), optionally a second go in cycle 2, return in cycle 4
    // after checking the result; the caller may issue the next go immediately.
    task automatic do_decode(input string tag, input logic [NT-1:0] t, input bit m,
                             input bit ovr_go, input int e_bl, input int e_bf, input int e_cnt);
        drive(1'b1, m, t);
        tick();
        drive(1'b0, m, t);
        check_val({tag, ".busy1"}, bus_l.busy, 1);
        check_val({tag, ".done1"}, bus_l.done, 0);
        tick();
        if (ovr_go) drive(1'b1, ~m, {$urandom, $urandom});
        check_val({tag, ".busy2"}, bus_l.busy, 1);
        tick();
        drive(1'b0, m, {$urandom, $urandom});
        check_val({tag, ".busy3"}, bus_l.busy, 1);
        check_val({tag, ".done3"}, bus_l.done, 0);
        tick();
        check_val({tag, ".done"},   bus_l.done, 1);
        check_val({tag, ".busy4"},  bus_l.busy, 0);
        check_val({tag, ".bin"},    bus_l.bin, e_bl);
        check_val({tag, ".cnt"},    bus_l.edge_count, e_cnt);
        check_val({tag, ".noe"},    bus_l.no_edge, (e_cnt == 0) ? 1 : 0);
        check_val({tag, ".mul"},    bus_l.multi_edge, (e_cnt > 1) ? 1 : 0);
        check_val({tag, ".ovr"},    bus_l.overrun, ovr_go ? 1 : 0);
        check_val({tag, ".f.done"}, bus_f.done, 1);
        check_val({tag, ".f.bin"},  bus_f.bin, e_bf);
        check_val({tag, ".f.cnt"},  bus_f.edge_count, e_cnt);
        last_bl = e_bl;
        last_bf = e_bf;
    endtask

    // One idle cycle after done: done must drop, results must hold.
    task automatic idle_check(input string tag);
        drive(1'b0, 1'b0, {$urandom, $urandom});
        tick();
        check_val({tag, ".done_lo"},  bus_l.done, 0);
        check_val({tag, ".hold"},     bus_l.bin, last_bl);
        check_val({tag, ".f.hold"},   bus_f.bin, last_bf);
    endtask

    initial begin
        logic [NT-1:0] t;
        logic [63:0]   w;
        bit            m;
        bit            og;
        int            k, bl, bf, cnt;

        drive(1'b0, 1'b0, '0);
        rst = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Directed scenarios from the test plan.
        do_decode("start8",   36'h0000000FF, 1'b0, 1'b0, 8, 8, 1);
        idle_check("start8");
        do_decode("stop12",   36'hFFFFFF000, 1'b1, 1'b0, 12, 12, 1);
        idle_check("stop12");
        do_decode("bubble",   36'h0001000FF, 1'b0, 1'b0, 21, 8, 2);
        idle_check("bubble");
        do_decode("zeros",    36'h000000000, 1'b0, 1'b0, 0, 0, 0);
        idle_check("zeros");
        do_decode("ones",     36'hFFFFFFFFF, 1'b0, 1'b0, 0, 0, 0);
        idle_check("ones");
        do_decode("top32",    36'h0FFFFFFFF, 1'b0, 1'b0, 32, 32, 1);
        idle_check("top32");
        do_decode("past_top", 36'h100000000, 1'b0, 1'b0, 0, 0, 0);
        idle_check("past_top");

        // Dropped go in cycle 2, then back-to-back go on the done cycle.
        do_decode("ovr",      36'h0000000FF, 1'b0, 1'b1, 8, 8, 1);
        do_decode("b2b",      36'hFFFFFF000, 1'b1, 1'b0, 12, 12, 1);
        idle_check("b2b");

        // Reset in cycle 2 of a decode aborts it with no done.
        drive(1'b1, 1'b0, 36'h0001000FF);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_idle_outputs($sformatf("rst_abort%0d", c));
            tick();
        end

        // Randomized decodes: noisy thermometer codes plus fully random vectors.
        for (int n = 0; n < 200; n++) begin
            m  = 1'($urandom_range(0, 1));
            og = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                t = {$urandom, $urandom};
            end else begin
                k = $urandom_range(0, NT);
                w = (64'd1 << k) - 64'd1;
                t = w[NT-1:0];
                if ($urandom_range(0, 1) == 0) t[$urandom_range(0, NT-1)] ^= 1'b1;
                if ($urandom_range(0, 3) == 0) t[$urandom_range(0, NT-1)] ^= 1'b1;
                if (m) t = ~t;
            end
            ref_decode(t, m, bl, bf, cnt);
            do_decode($sformatf("rnd%0d", n), t, m, og, bl, bf, cnt);
            if ($urandom_range(0, 2) == 0) idle_check($sformatf("rnd%0d", n));
        end

        drive(1'b0, 1'b0, '0);
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
